// File: rtl/regfile_multiport.sv
// Parametrised multi-port register file for the multi-cycle core.
//
// After reset the file clears itself, one entry per cycle, while init_busy_o is high. It then
// serves NUM_READ_PORTS registered read ports (latency 1) and one write port. A write to the
// same address a port is reading can be forwarded in the same cycle. Register 0 can be made
// to read as zero.
//
// Ports:
//   clk_i        rising-edge clock
//   rst_ni       synchronous, active-low reset; restarts the clear sequence
//   rd_en_i      per-port read request
//   rd_addr_i    packed read addresses, port p at [p*AW +: AW]
//   rd_data_o    packed read data, port p at [p*XLEN +: XLEN]; holds when not read
//   rd_valid_o   per-port flag: rd_data_o for that port was loaded by the last edge
//   wr_en_i      write request
//   wr_addr_i    write address
//   wr_data_i    write data
//   init_busy_o  high while the clear sequence runs
module regfile_multiport #(
    parameter int unsigned XLEN           = 32,
    parameter int unsigned NUM_REGS       = 32,
    parameter int unsigned NUM_READ_PORTS = 2,
    parameter int unsigned ZERO_REG       = 1,
    parameter int unsigned BYPASS         = 1,
    localparam int unsigned AW            = $clog2(NUM_REGS)
) (
    input  logic                           clk_i,
    input  logic                           rst_ni,
    input  logic [NUM_READ_PORTS-1:0]      rd_en_i,
    input  logic [NUM_READ_PORTS*AW-1:0]   rd_addr_i,
    output logic [NUM_READ_PORTS*XLEN-1:0] rd_data_o,
    output logic [NUM_READ_PORTS-1:0]      rd_valid_o,
    input  logic                           wr_en_i,
    input  logic [AW-1:0]                  wr_addr_i,
    input  logic [XLEN-1:0]                wr_data_i,
    output logic                           init_busy_o
);

    typedef enum logic [0:0] {StInit, StRun} state_e;

    // One bit wider than an address so the terminal count never aliases entry 0.
    localparam logic [AW:0] LastPtr = (AW + 1)'(NUM_REGS - 1);
    localparam logic [AW:0] PtrOne  = (AW + 1)'(1);

    state_e                           state_q, state_d;
    logic [AW:0]                      ptr_q, ptr_d;
    logic                             busy_q, busy_d;
    logic [NUM_READ_PORTS*XLEN-1:0]   rd_data_q, rd_data_d;
    logic [NUM_READ_PORTS-1:0]        rd_valid_q, rd_valid_d;
    logic [XLEN-1:0]                  mem_q [NUM_REGS];

    logic                             clr_en;
    logic                             wr_legal;
    logic [NUM_READ_PORTS*XLEN-1:0]   rd_val;

    assign clr_en   = rst_ni && (state_q == StInit);
    assign wr_legal = rst_ni && (state_q == StRun) && wr_en_i
                      && (32'(wr_addr_i) < NUM_REGS)
                      && !((ZERO_REG != 0) && (wr_addr_i == '0));

    // Storage has no reset of its own; the clear sequence is the only way to zero it.
    always_ff @(posedge clk_i) begin
        if (clr_en) begin
            mem_q[ptr_q[AW-1:0]] <= '0;
        end else if (wr_legal) begin
            mem_q[wr_addr_i] <= wr_data_i;
        end
    end

    // Per-port read value: out of range, then the zero register, then the bypass, then storage.
    for (genvar p = 0; p < NUM_READ_PORTS; p++) begin : g_rd
        logic [AW-1:0] addr;
        assign addr = rd_addr_i[p*AW +: AW];
        assign rd_val[p*XLEN +: XLEN] =
            (32'(addr) >= NUM_REGS)                            ? {XLEN{1'b0}} :
            ((ZERO_REG != 0) && (addr == '0))                  ? {XLEN{1'b0}} :
            ((BYPASS != 0) && wr_legal && (wr_addr_i == addr)) ? wr_data_i    :
                                                                 mem_q[addr];
    end

    always_comb begin
        state_d    = state_q;
        ptr_d      = ptr_q;
        busy_d     = busy_q;
        rd_data_d  = rd_data_q;
        rd_valid_d = '0;
        unique case (state_q)
            StInit: begin
                busy_d = 1'b1;
                ptr_d  = ptr_q + PtrOne;
                if (ptr_q == LastPtr) begin
                    state_d = StRun;
                    busy_d  = 1'b0;
                end
            end
            StRun: begin
                busy_d = 1'b0;
                for (int unsigned p = 0; p < NUM_READ_PORTS; p++) begin
                    if (rd_en_i[p]) begin
                        rd_valid_d[p]              = 1'b1;
                        rd_data_d[p*XLEN +: XLEN]  = rd_val[p*XLEN +: XLEN];
                    end
                end
            end
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q    <= StInit;
            ptr_q      <= '0;
            busy_q     <= 1'b1;
            rd_data_q  <= '0;
            rd_valid_q <= '0;
        end else begin
            state_q    <= state_d;
            ptr_q      <= ptr_d;
            busy_q     <= busy_d;
            rd_data_q  <= rd_data_d;
            rd_valid_q <= rd_valid_d;
        end
    end

    assign rd_data_o   = rd_data_q;
    assign rd_valid_o  = rd_valid_q;
    assign init_busy_o = busy_q;

endmodule

// File: tb/tb_regfile_multiport.sv
// Bench for regfile_multiport. Two instances share all inputs:
//   u_dut_a: 32 regs, zero register on, bypass on
//   u_dut_b: 24 regs, zero register off, bypass off
module tb_regfile_multiport;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [1:0]  rd_en;
    logic [9:0]  rd_addr;
    logic        wr_en;
    logic [4:0]  wr_addr;
    logic [31:0] wr_data;
    logic [63:0] rd_data_a, rd_data_b;
    logic [1:0]  rd_valid_a, rd_valid_b;
    logic        busy_a, busy_b;

    always #5 clk = ~clk;

    regfile_multiport #(
        .XLEN(32), .NUM_REGS(32), .NUM_READ_PORTS(2), .ZERO_REG(1), .BYPASS(1)
    ) u_dut_a (
        .clk_i(clk), .rst_ni(rst_n), .rd_en_i(rd_en), .rd_addr_i(rd_addr),
        .rd_data_o(rd_data_a), .rd_valid_o(rd_valid_a), .wr_en_i(wr_en),
        .wr_addr_i(wr_addr), .wr_data_i(wr_data), .init_busy_o(busy_a)
    );

    regfile_multiport #(
        .XLEN(32), .NUM_REGS(24), .NUM_READ_PORTS(2), .ZERO_REG(0), .BYPASS(0)
    ) u_dut_b (
        .clk_i(clk), .rst_ni(rst_n), .rd_en_i(rd_en), .rd_addr_i(rd_addr),
        .rd_data_o(rd_data_b), .rd_valid_o(rd_valid_b), .wr_en_i(wr_en),
        .wr_addr_i(wr_addr), .wr_data_i(wr_data), .init_busy_o(busy_b)
    );

    int n_checks = 0;
    int n_errors = 0;

    typedef struct {
        logic        wen;
        logic [4:0]  wa;
        logic [31:0] wd;
        logic [1:0]  ren;
        logic [4:0]  ra0, ra1;
        logic [31:0] ea0, ea1, eb0, eb1;
        string       name;
    } vec_t;

    typedef struct {
        logic [1:0]  ren;
        logic [31:0] da0, da1, db0, db1;
        string       name;
    } exp_t;

    vec_t vecs[$];
    exp_t sb_q[$];
    logic [31:0] last_a0, last_a1, last_b0, last_b1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic add_vec(input logic wen, input logic [4:0] wa, input logic [31:0] wd,
                           input logic [1:0] ren, input logic [4:0] ra0, input logic [4:0] ra1,
                           input logic [31:0] ea0, input logic [31:0] ea1,
                           input logic [31:0] eb0, input logic [31:0] eb1, input string name);
        vec_t v;
        v.wen = wen; v.wa = wa; v.wd = wd; v.ren = ren; v.ra0 = ra0; v.ra1 = ra1;
        v.ea0 = ea0; v.ea1 = ea1; v.eb0 = eb0; v.eb1 = eb1; v.name = name;
        vecs.push_back(v);
    endtask

    // Drive one RUN cycle, push the expected outputs, then pop and compare after the edge.
    // Ports not read are expected to hold their previous data.
    task automatic step(input vec_t v);
        exp_t e;
        @(negedge clk);
        wr_en   = v.wen;
        wr_addr = v.wa;
        wr_data = v.wd;
        rd_en   = v.ren;
        rd_addr = {v.ra1, v.ra0};
        if (v.ren[0]) begin last_a0 = v.ea0; last_b0 = v.eb0; end
        if (v.ren[1]) begin last_a1 = v.ea1; last_b1 = v.eb1; end
        e.ren = v.ren; e.name = v.name;
        e.da0 = last_a0; e.da1 = last_a1; e.db0 = last_b0; e.db1 = last_b1;
        sb_q.push_back(e);
        @(posedge clk);
        #1;
        if (sb_q.size() == 0) begin
            check({v.name, "/sb_empty"}, 32'd1, 32'd0);
        end else begin
            e = sb_q.pop_front();
            check({e.name, "/a.valid"}, 32'(rd_valid_a), 32'(e.ren));
            check({e.name, "/a.data0"}, rd_data_a[31:0], e.da0);
            check({e.name, "/a.data1"}, rd_data_a[63:32], e.da1);
            check({e.name, "/b.valid"}, 32'(rd_valid_b), 32'(e.ren));
            check({e.name, "/b.data0"}, rd_data_b[31:0], e.db0);
            check({e.name, "/b.data1"}, rd_data_b[63:32], e.db1);
        end
    endtask

    task automatic do_reset(input int ncyc, input string tag);
        @(negedge clk);
        rst_n = 1'b0;
        wr_en = 1'b0;
        rd_en = 2'b00;
        repeat (ncyc) @(posedge clk);
        #1;
        check({tag, "/busy_a"}, 32'(busy_a), 32'd1);
        check({tag, "/busy_b"}, 32'(busy_b), 32'd1);
        check({tag, "/valid"}, 32'({rd_valid_a, rd_valid_b}), 32'd0);
        check({tag, "/data_a"}, rd_data_a[31:0] | rd_data_a[63:32], 32'd0);
        check({tag, "/data_b"}, rd_data_b[31:0] | rd_data_b[63:32], 32'd0);
        last_a0 = '0; last_a1 = '0; last_b0 = '0; last_b1 = '0;
    endtask

    // Release reset and count edges until each busy flag falls; writes and reads are
    // attempted during the first cycles of the clear and must have no visible effect.
    task automatic wait_init(input string tag);
        int  ca = 0;
        int  cb = 0;
        logic vbad = 1'b0;
        for (int n = 1; n <= 100 && (ca == 0 || cb == 0); n++) begin
            @(negedge clk);
            rst_n = 1'b1;
            if (n <= 10) begin
                wr_en   = 1'b1;
                wr_addr = 5'(n + 3);
                wr_data = 32'hBAD0_0000 + 32'(n);
                rd_en   = 2'b11;
                rd_addr = {5'd3, 5'd9};
            end else begin
                wr_en = 1'b0;
                rd_en = 2'b00;
            end
            @(posedge clk);
            #1;
            if (rd_valid_a != 2'b00 || rd_valid_b != 2'b00) vbad = 1'b1;
            if (ca == 0 && !busy_a) ca = n;
            if (cb == 0 && !busy_b) cb = n;
        end
        check({tag, "/busy_cycles_a"}, 32'(ca), 32'd32);
        check({tag, "/busy_cycles_b"}, 32'(cb), 32'd24);
        check({tag, "/valid_in_init"}, 32'(vbad), 32'd0);
    endtask

    function automatic logic [31:0] fill_exp(input logic is_b, input int r);
        if (!is_b) return (r == 0) ? 32'd0 : 32'(r);
        if (r == 0) return 32'hFFFF_FFFF;
        return (r < 24) ? 32'(r) : 32'd0;
    endfunction

    // Read every address on both ports; filled=0 expects an all-zero file.
    task automatic sweep(input logic filled, input string tag);
        vec_t v;
        for (int r = 0; r < 32; r++) begin
            v.wen = 1'b0; v.wa = '0; v.wd = '0; v.ren = 2'b11;
            v.ra0 = 5'(r); v.ra1 = 5'(31 - r);
            v.ea0 = filled ? fill_exp(1'b0, r)      : 32'd0;
            v.ea1 = filled ? fill_exp(1'b0, 31 - r) : 32'd0;
            v.eb0 = filled ? fill_exp(1'b1, r)      : 32'd0;
            v.eb1 = filled ? fill_exp(1'b1, 31 - r) : 32'd0;
            v.name = $sformatf("%s[%0d]", tag, r);
            step(v);
        end
    endtask

    initial begin
        vec_t v;
        rst_n = 1'b0; rd_en = '0; rd_addr = '0; wr_en = 1'b0; wr_addr = '0; wr_data = '0;
        last_a0 = '0; last_a1 = '0; last_b0 = '0; last_b1 = '0;

        //       wen   wa     wd            ren    ra0    ra1    ea0           ea1
        //       eb0           eb1
        add_vec(1'b1, 5'd5,  32'hDEADBEEF, 2'b00, 5'd0,  5'd0,  32'h0,        32'h0,
                32'h0,        32'h0,        "wr_x5");
        add_vec(1'b0, 5'd0,  32'h0,        2'b11, 5'd5,  5'd0,  32'hDEADBEEF, 32'h0,
                32'hDEADBEEF, 32'h0,        "rd_x5");
        add_vec(1'b1, 5'd7,  32'h12345678, 2'b11, 5'd7,  5'd7,  32'h12345678, 32'h12345678,
                32'h0,        32'h0,        "bypass_x7");
        add_vec(1'b0, 5'd0,  32'h0,        2'b11, 5'd7,  5'd7,  32'h12345678, 32'h12345678,
                32'h12345678, 32'h12345678, "rd_x7");
        add_vec(1'b1, 5'd0,  32'hFFFFFFFF, 2'b00, 5'd0,  5'd0,  32'h0,        32'h0,
                32'h0,        32'h0,        "wr_x0");
        add_vec(1'b0, 5'd0,  32'h0,        2'b11, 5'd0,  5'd5,  32'h0,        32'hDEADBEEF,
                32'hFFFFFFFF, 32'hDEADBEEF, "rd_x0");
        add_vec(1'b1, 5'd0,  32'hFFFFFFFF, 2'b01, 5'd0,  5'd0,  32'h0,        32'h0,
                32'hFFFFFFFF, 32'h0,        "wr_rd_x0");
        add_vec(1'b1, 5'd30, 32'h000000AA, 2'b11, 5'd30, 5'd23, 32'h000000AA, 32'h0,
                32'h0,        32'h0,        "wr_rd_30");
        add_vec(1'b0, 5'd0,  32'h0,        2'b11, 5'd30, 5'd23, 32'h000000AA, 32'h0,
                32'h0,        32'h0,        "rd_30");
        add_vec(1'b1, 5'd23, 32'h23232323, 2'b11, 5'd23, 5'd31, 32'h23232323, 32'h0,
                32'h0,        32'h0,        "wr_rd_23");
        add_vec(1'b0, 5'd0,  32'h0,        2'b11, 5'd23, 5'd23, 32'h23232323, 32'h23232323,
                32'h23232323, 32'h23232323, "rd_23");
        add_vec(1'b1, 5'd24, 32'h00000055, 2'b00, 5'd0,  5'd0,  32'h0,        32'h0,
                32'h0,        32'h0,        "wr_24");
        add_vec(1'b0, 5'd0,  32'h0,        2'b11, 5'd24, 5'd5,  32'h00000055, 32'hDEADBEEF,
                32'h0,        32'hDEADBEEF, "rd_24");
        add_vec(1'b1, 5'd7,  32'h0BADF00D, 2'b10, 5'd0,  5'd7,  32'h0,        32'h0BADF00D,
                32'h0,        32'h12345678, "bypass_p1");
        add_vec(1'b0, 5'd0,  32'h0,        2'b11, 5'd7,  5'd30, 32'h0BADF00D, 32'h000000AA,
                32'h0BADF00D, 32'h0,        "rd_7_30");

        // Power-on clear, then the whole file reads zero.
        do_reset(2, "rst0");
        wait_init("init0");
        sweep(1'b0, "clr0");

        foreach (vecs[i]) step(vecs[i]);

        // Fill x1..x31 with their own index and read it back.
        for (int r = 1; r < 32; r++) begin
            v.wen = 1'b1; v.wa = 5'(r); v.wd = 32'(r); v.ren = 2'b00;
            v.ra0 = '0; v.ra1 = '0; v.ea0 = '0; v.ea1 = '0; v.eb0 = '0; v.eb1 = '0;
            v.name = $sformatf("fill[%0d]", r);
            step(v);
        end
        sweep(1'b1, "fill");

        // Second clear, interrupted by reset at clear cycle 10; it must restart in full.
        do_reset(1, "rst1");
        for (int n = 0; n < 10; n++) begin
            @(negedge clk);
            rst_n   = 1'b1;
            wr_en   = 1'b1;
            wr_addr = 5'd9;
            wr_data = 32'h0000_0099;
            rd_en   = 2'b11;
            @(posedge clk);
        end
        #1;
        check("mid_init/busy_a", 32'(busy_a), 32'd1);
        check("mid_init/busy_b", 32'(busy_b), 32'd1);
        do_reset(1, "rst2");
        wait_init("init2");
        sweep(1'b0, "clr2");

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
